uart_tx_buffered: RTL

// Buffered UART transmit engine, the transmit counterpart of the UART receive

---
 rtl/uart_tx_buffered.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter.
// Byte FIFO drained back-to-back by a serializer.
module uart_tx_buffered #(
  parameter int FIFO_LENGTH   = 8,
  parameter int DIVISOR_WIDTH = 16,
  parameter int LOW_WATERMARK = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DIVISOR_WIDTH-1:0] clocks_per_bit,
  input  logic                     tx_en,
  input  logic [7:0]               tx_char,
  input  logic                     clear_overrun,
  output logic                     tx_ready,
  output logic                     tx_idle,
  output logic                     tx_overrun,
  output logic                     tx_interrupt,
  output logic                     uart_tx
);

  localparam int AW = $clog2(FIFO_LENGTH);
  localparam int CW = AW + 1;
  localparam int DW = DIVISOR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]    mem [FIFO_LENGTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  state_t        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [DW-1:0] div_eff;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          bit_last;

  assign full  = (count == CW'(FIFO_LENGTH));
  assign empty = (count == '0);
  assign push  = tx_en & ~full;

  assign tx_ready     = ~full;
  assign tx_idle      = empty & (state_q == IDLE);
  assign tx_interrupt = (count <= CW'(LOW_WATERMARK));

  assign div_eff  = (clocks_per_bit == '0) ? DW'(1) : clocks_per_bit;
  assign bit_last = (cnt_q == div_q - DW'(1));

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_char;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overrun; a new drop beats a clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_overrun <= 1'b0;
    end else if (tx_en && full) begin
      tx_overrun <= 1'b1;
    end else if (clear_overrun) begin
      tx_overrun <= 1'b0;
    end
  end

  // Serializer state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DW'(1);
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Serializer next state; frames chain without idle gap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          div_d   = div_eff;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_last) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_last) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_last) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            div_d   = div_eff;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line driver from registered state
  always_comb begin
    uart_tx = 1'b1;
    unique case (state_q)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = shift_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

endmodule
